// File: rtl/mma_arb_pkg.sv
// mma_arb_pkg: shared definitions for the MMA ICB port arbiter.
//   - Requester index map (OA, IA, WEIGHT, BIAS, QUANT) and requester count.
//   - arb_state_e: IDLE -> GRANT -> RELEASE -> IDLE arbitration FSM states.
//   - ICB_SEL_NONE: icb_sel encoding used when no grant is held.
package mma_arb_pkg;

  localparam int unsigned NUM_REQ    = 5;
  localparam int unsigned REQ_OA     = 0;
  localparam int unsigned REQ_IA     = 1;
  localparam int unsigned REQ_WEIGHT = 2;
  localparam int unsigned REQ_BIAS   = 3;
  localparam int unsigned REQ_QUANT  = 4;

  localparam int unsigned ICB_SEL_NONE = NUM_REQ;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_e;

endpackage

// File: rtl/mma_rr_picker.sv
// mma_rr_picker: combinational round-robin winner selection.
//   i_req    - per-requester level requests
//   i_ptr    - round-robin start index (highest priority this round)
//   i_urgent - when set and requester 0 (OA) requests, OA wins outright
//   o_winner - index of the selected requester (0 when nothing requests)
//   o_valid  - at least one request is present
module mma_rr_picker #(
  parameter int unsigned N_REQ = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_urgent,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);
  import mma_arb_pkg::*;

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    if (i_urgent && i_req[REQ_OA]) begin
      o_winner = IDX_W'(REQ_OA);
      o_valid  = 1'b1;
    end else begin
      // Scan from the pointer upward, wrapping; first set bit wins.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        w_idx = IDX_W'((32'(i_ptr) + i) % N_REQ);
        if (!o_valid && i_req[w_idx]) begin
          o_winner = w_idx;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mma_icb_arbiter.sv
// mma_icb_arbiter: shares the single ICB memory port between the MMA data movers.
//   clk, rst      - clock and synchronous active-high reset
//   req, done     - per-requester level request and one-cycle completion pulse
//   urgent        - output FIFO full: OA wins the next arbitration
//   gnt, icb_sel  - registered one-hot grant and its encoded index (NUM_REQ when idle)
//   busy          - a grant is held
//   timeout_err   - sticky watchdog-release flag; timeout_id holds the last offender
module mma_icb_arbiter #(
  parameter int unsigned NUM_REQ        = 5,
  parameter int unsigned SEL_WIDTH      = 3,
  parameter int unsigned MAX_HOLD       = 1024,
  parameter int unsigned HOLD_CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   done,
  input  logic                 urgent,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_WIDTH-1:0] icb_sel,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [SEL_WIDTH-1:0] timeout_id
);
  import mma_arb_pkg::*;

  localparam logic [SEL_WIDTH-1:0] SelIdle = SEL_WIDTH'(NUM_REQ);

  arb_state_e               r_state, w_state_d;
  logic [NUM_REQ-1:0]       r_gnt, w_gnt_d;
  logic [SEL_WIDTH-1:0]     r_sel, w_sel_d;
  logic [SEL_WIDTH-1:0]     r_ptr, w_ptr_d;
  logic [HOLD_CNT_WIDTH-1:0] r_cnt, w_cnt_d;
  logic                     r_terr, w_terr_d;
  logic [SEL_WIDTH-1:0]     r_tid, w_tid_d;

  logic [SEL_WIDTH-1:0] w_win;
  logic                 w_valid;
  logic                 w_rel_done, w_rel_wd, w_rel_to;

  mma_rr_picker #(
    .N_REQ (NUM_REQ),
    .IDX_W (SEL_WIDTH)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .i_urgent (urgent),
    .o_winner (w_win),
    .o_valid  (w_valid)
  );

  // Release sources for the current grantee; only meaningful in ARB_GRANT.
  assign w_rel_done = |(done & r_gnt);
  assign w_rel_wd   = ~|(req & r_gnt);
  assign w_rel_to   = (r_cnt == HOLD_CNT_WIDTH'(MAX_HOLD - 1));

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    w_terr_d  = r_terr;
    w_tid_d   = r_tid;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_valid) begin
          w_state_d = ARB_GRANT;
          w_gnt_d   = NUM_REQ'(1) << w_win;
          w_sel_d   = w_win;
          w_ptr_d   = (w_win == SEL_WIDTH'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
          w_cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        w_cnt_d = r_cnt + 1'b1;
        if (w_rel_done || w_rel_wd || w_rel_to) begin
          w_state_d = ARB_RELEASE;
          w_gnt_d   = '0;
          w_sel_d   = SelIdle;
          // A normal completion in the same cycle masks the watchdog.
          if (w_rel_to && !w_rel_done && !w_rel_wd) begin
            w_terr_d = 1'b1;
            w_tid_d  = r_sel;
          end
        end
      end
      ARB_RELEASE: begin
        w_state_d = ARB_IDLE;
      end
      default: begin
        w_state_d = ARB_IDLE;
        w_gnt_d   = '0;
        w_sel_d   = SelIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_sel   <= SelIdle;
      r_ptr   <= SEL_WIDTH'(1);
      r_cnt   <= '0;
      r_terr  <= 1'b0;
      r_tid   <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
      r_terr  <= w_terr_d;
      r_tid   <= w_tid_d;
    end
  end

  assign gnt         = r_gnt;
  assign icb_sel     = r_sel;
  assign busy        = |r_gnt;
  assign timeout_err = r_terr;
  assign timeout_id  = r_tid;

endmodule

// File: tb/tb_mma_icb_arbiter.sv
// tb_mma_icb_arbiter: directed bench for mma_icb_arbiter with a cycle-level reference model
// (MAX_HOLD reduced to 8 so the watchdog is reachable quickly).
module tb_mma_icb_arbiter;
  localparam int N  = 5;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] done;
  logic       urgent;
  logic [4:0] gnt;
  logic [2:0] icb_sel;
  logic       busy;
  logic       timeout_err;
  logic [2:0] timeout_id;

  mma_icb_arbiter #(
    .NUM_REQ        (5),
    .SEL_WIDTH      (3),
    .MAX_HOLD       (MH),
    .HOLD_CNT_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .urgent      (urgent),
    .gnt         (gnt),
    .icb_sel     (icb_sel),
    .busy        (busy),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whether we are in the turnaround cycle,
  // the round-robin start index, cycles granted so far and the sticky error.
  typedef struct {
    int owner;
    bit rel;
    int ptr;
    int held;
    bit terr;
    int tid;
  } mstate_t;

  mstate_t m;
  bit      m_ok = 1'b0;

  function automatic bit bit_at(input logic [4:0] v, input int i);
    return v[i[2:0]];
  endfunction

  function automatic logic [4:0] exp_gnt(input int o);
    if (o < 0) return 5'b0;
    return 5'b00001 << o[2:0];
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [4:0] rq,
                                         input logic [4:0] dn, input logic ur, input logic rs);
    mstate_t n = s;
    if (rs) begin
      n.owner = -1; n.rel = 1'b0; n.ptr = 1; n.held = 0; n.terr = 1'b0; n.tid = 0;
    end else if (s.rel) begin
      n.rel = 1'b0;
    end else if (s.owner >= 0) begin
      bit fin     = bit_at(dn, s.owner);
      bit gone    = !bit_at(rq, s.owner);
      bit expired = (s.held + 1 >= MH);
      n.held = s.held + 1;
      if (fin || gone || expired) begin
        n.owner = -1;
        n.rel   = 1'b1;
        if (!fin && !gone) begin
          n.terr = 1'b1;
          n.tid  = s.owner;
        end
      end
    end else if (|rq) begin
      int w = -1;
      if (ur && bit_at(rq, 0)) w = 0;
      else begin
        for (int k = 0; k < N; k++) begin
          int c = (s.ptr + k) % N;
          if (w < 0 && bit_at(rq, c)) w = c;
        end
      end
      n.owner = w;
      n.ptr   = (w + 1) % N;
      n.held  = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_step(m, req, done, urgent, rst);
    if (rst) m_ok <= 1'b1;
  end

  // Per-cycle comparison against the model, plus a log of grant start indices.
  bit prev_busy = 1'b0;
  int glog[$];

  always @(negedge clk) begin
    if (m_ok) begin
      check("gnt", 32'(gnt), 32'(exp_gnt(m.owner)));
      check("icb_sel", 32'(icb_sel), 32'(m.owner >= 0 ? m.owner : N));
      check("busy", 32'(busy), 32'(m.owner >= 0));
      check("timeout_err", 32'(timeout_err), 32'(m.terr));
      check("timeout_id", 32'(timeout_id), 32'(m.tid));
      if (busy && !prev_busy) glog.push_back(int'(icb_sel));
      prev_busy <= busy;
    end
  end

  task automatic wait_busy(input string name, output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: no grant within 40 cycles", name);
  endtask

  task automatic pulse_done(input int idx, input logic [4:0] req_after);
    done = 5'b00001 << idx;
    @(negedge clk);
    done = 5'b0;
    req  = req_after;
  endtask

  int lat;
  int cnt;
  int exp_order[6] = '{1, 2, 3, 4, 0, 1};

  initial begin
    rst = 1'b1; req = 5'b0; done = 5'b0; urgent = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(icb_sel), 32'd5);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // Single requester, 1-cycle latency, pointer left at 3.
    @(negedge clk); req = 5'b00100;
    wait_busy("t1", lat);
    check("t1_latency", 32'(lat), 32'd1);
    check("t1_gnt", 32'(gnt), 32'h04);
    check("t1_sel", 32'(icb_sel), 32'd2);
    repeat (8) @(negedge clk);
    pulse_done(2, 5'b0);
    check("t1_release_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    req = 5'b00101;
    wait_busy("t1_ptr", lat);
    check("t1_ptr_sel", 32'(icb_sel), 32'd0);
    pulse_done(0, 5'b0);

    // Round-robin over all requesters.
    @(negedge clk);
    glog.delete();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      wait_busy("t2", lat);
      repeat (2) @(negedge clk);
      pulse_done(int'(icb_sel), (k == 5) ? 5'b0 : 5'b11111);
    end
    @(negedge clk);
    check("t2_count", 32'(glog.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < glog.size()) check("t2_order", 32'(glog[k]), 32'(exp_order[k]));
    end

    // Urgent override with pointer at 3.
    req = 5'b00100;
    wait_busy("t3_prep", lat);
    check("t3_prep_sel", 32'(icb_sel), 32'd2);
    pulse_done(2, 5'b0);
    @(negedge clk);
    req = 5'b11001; urgent = 1'b1;
    wait_busy("t3_oa", lat);
    check("t3_oa_sel", 32'(icb_sel), 32'd0);
    urgent = 1'b0;
    @(negedge clk);
    pulse_done(0, 5'b11000);
    wait_busy("t3_next", lat);
    check("t3_next_sel", 32'(icb_sel), 32'd3);
    pulse_done(3, 5'b10000);
    wait_busy("t3_last", lat);
    check("t3_last_sel", 32'(icb_sel), 32'd4);
    pulse_done(4, 5'b0);

    // Urgent raised during an IA grant does not preempt it.
    @(negedge clk);
    req = 5'b00010;
    wait_busy("t4", lat);
    check("t4_ia_sel", 32'(icb_sel), 32'd1);
    req = 5'b00111; urgent = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_ia_hold", 32'(gnt), 32'h02);
    end
    pulse_done(1, 5'b00101);
    wait_busy("t4_oa", lat);
    check("t4_oa_sel", 32'(icb_sel), 32'd0);
    urgent = 1'b0;
    pulse_done(0, 5'b0);

    // Watchdog release after MAX_HOLD grant cycles.
    @(negedge clk);
    req = 5'b10000;
    wait_busy("t5", lat);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("t5_hold_cycles", 32'(cnt), 32'd8);
    check("t5_terr", 32'(timeout_err), 32'd1);
    check("t5_tid", 32'(timeout_id), 32'd4);
    @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t5_regrant_gnt", 32'(gnt), 32'h10);
    req = 5'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_terr_sticky", 32'(timeout_err), 32'd1);
    check("t5_tid_sticky", 32'(timeout_id), 32'd4);

    // Withdrawal, stray done, reset mid-grant.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_terr_cleared", 32'(timeout_err), 32'd0);
    req = 5'b00100;
    wait_busy("t6", lat);
    repeat (2) @(negedge clk);
    req = 5'b0;
    @(negedge clk);
    check("t6_withdraw_gnt", 32'(gnt), 32'h0);
    check("t6_withdraw_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    done = 5'b01000;
    @(negedge clk);
    done = 5'b0;
    check("t6_stray_done_gnt", 32'(gnt), 32'h0);
    req = 5'b00010;
    wait_busy("t6_rst", lat);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_gnt", 32'(gnt), 32'h0);
    check("t6_rst_sel", 32'(icb_sel), 32'd5);
    rst = 1'b0; req = 5'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
